// File: rtl/branch_comp.sv
// branch_comp: multi-cycle RISC-V branch comparator, one CHUNK of the operands per cycle, MSB chunk first
module branch_comp #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] src_1,
   input  logic [WIDTH-1:0] src_2,
   input  logic [2:0]       op,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             taken,
   output logic             equal,
   output logic             less,
   output logic             signed_less,
   output logic             illegal
);
   localparam int NCH = WIDTH / CHUNK;
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IW-1:0] TOP = IW'(NCH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] src1_q, src1_d, src2_q, src2_d;
   logic [2:0]       op_q, op_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             taken_q, taken_d, equal_q, equal_d, less_q, less_d;
   logic             slt_q, slt_d, ill_q, ill_d;
   logic [CHUNK-1:0] c1, c2;
   logic             ch_eq, ch_lt, ch_slt, ch_tk, decide;

   assign in_ready    = rst_n && (state_q == IDLE) && !flush;
   assign out_valid   = (state_q == DONE);
   assign taken       = taken_q;
   assign equal       = equal_q;
   assign less        = less_q;
   assign signed_less = slt_q;
   assign illegal     = ill_q;

   // next state: accept/latch in IDLE, one chunk compare per BUSY cycle, hold results in DONE
   always_comb begin
      state_d = state_q;
      src1_d  = src1_q;
      src2_d  = src2_q;
      op_d    = op_q;
      idx_d   = idx_q;
      taken_d = taken_q;
      equal_d = equal_q;
      less_d  = less_q;
      slt_d   = slt_q;
      ill_d   = ill_q;
      c1      = src1_q[CHUNK*idx_q +: CHUNK];
      c2      = src2_q[CHUNK*idx_q +: CHUNK];
      ch_eq   = (c1 == c2);
      ch_lt   = (c1 < c2);
      ch_slt  = ((idx_q == TOP) && (src1_q[WIDTH-1] != src2_q[WIDTH-1])) ? src1_q[WIDTH-1] : ch_lt;
      ch_tk   = (op_q[2] ? (op_q[1] ? ch_lt : ch_slt) : ch_eq) ^ op_q[0];
      decide  = !ch_eq || (idx_q == '0);
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (in_valid && in_ready) begin
               src1_d = src_1;
               src2_d = src_2;
               op_d   = op;
               idx_d  = TOP;
               if (op[2:1] == 2'b01) begin
                  state_d = DONE;
                  taken_d = 1'b0;
                  equal_d = 1'b0;
                  less_d  = 1'b0;
                  slt_d   = 1'b0;
                  ill_d   = 1'b1;
               end else begin
                  state_d = BUSY;
               end
            end
            BUSY: if (decide) begin
               state_d = DONE;
               taken_d = ch_tk;
               equal_d = ch_eq;
               less_d  = ch_lt;
               slt_d   = ch_slt;
               ill_d   = 1'b0;
            end else begin
               idx_d = idx_q - 1'b1;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // state, operand and result registers; reset clears everything asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         src1_q  <= '0;
         src2_q  <= '0;
         op_q    <= '0;
         idx_q   <= '0;
         taken_q <= 1'b0;
         equal_q <= 1'b0;
         less_q  <= 1'b0;
         slt_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src1_q  <= src1_d;
         src2_q  <= src2_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         taken_q <= taken_d;
         equal_q <= equal_d;
         less_q  <= less_d;
         slt_q   <= slt_d;
         ill_q   <= ill_d;
      end
   end
endmodule

// File: tb/tb_branch_comp.sv
// tb_branch_comp: directed vectors against a behavioural branch-compare model for branch_comp
module tb_branch_comp;
   localparam int W = 32;
   localparam int C = 8;
   localparam int N = W / C;

   logic         clk = 0, rst_n = 1, in_valid = 0, flush = 0, out_ready = 0;
   logic [W-1:0] src_1 = 0, src_2 = 0;
   logic [2:0]   op = 0;
   logic         in_ready, out_valid, taken, equal, less, signed_less, illegal;

   int   nvec = 0, nerr = 0, cyc = 0, acc_cyc = 0, exp_lat = 0;
   bit   pending = 0, seen = 0;
   logic [4:0] exp_res = 0;

   branch_comp #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .src_1(src_1), .src_2(src_2), .op(op), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .equal(equal),
      .less(less), .signed_less(signed_less), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // result vector order: {taken, equal, less, signed_less, illegal}
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                                 output logic [4:0] r, output int lat);
      logic eq, lt, slt, tk;
      int   p;
      eq  = (a == b);
      lt  = (a < b);
      slt = ($signed(a) < $signed(b));
      case (o)
         3'b000: tk = eq;
         3'b001: tk = !eq;
         3'b100: tk = slt;
         3'b101: tk = !slt;
         3'b110: tk = lt;
         3'b111: tk = !lt;
         default: tk = 1'b0;
      endcase
      if (o == 3'b010 || o == 3'b011) begin
         r   = 5'b00001;
         lat = 1;
      end else begin
         p = -1;
         for (int i = 0; i < W; i++) if (a[i] != b[i]) p = i;
         lat = (p < 0) ? N + 1 : N - p / C + 1;
         r   = {tk, eq, lt, slt, 1'b0};
      end
   endfunction

   // compare process: every negedge, check DUT against the model for the in-flight request
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         pending = 0;
      end else begin
         if (pending) begin
            if (out_valid) begin
               if (!seen) begin
                  chk("latency", cyc - acc_cyc, exp_lat);
                  seen = 1;
               end
               chk("result", {taken, equal, less, signed_less, illegal}, exp_res);
               chk("in_ready_done", in_ready, 0);
            end else if (seen) begin
               pending = 0;
            end else if (cyc - acc_cyc > N + 2) begin
               nvec++;
               nerr++;
               $display("FAIL timeout: no out_valid after %0d cycles", cyc - acc_cyc);
               pending = 0;
            end
            if (flush) pending = 0;
         end else begin
            chk("no_result", out_valid, 0);
         end
         if (in_valid && in_ready) begin
            model(src_1, src_2, op, exp_res, exp_lat);
            pending = 1;
            seen    = 0;
            acc_cyc = cyc;
         end
      end
   end

   task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                      input logic [4:0] lit, input int lit_lat, input int d);
      logic [4:0] r;
      int l;
      bit got;
      model(a, b, o, r, l);
      chk("model_res", r, lit);
      chk("model_lat", l, lit_lat);
      @(posedge clk); #1;
      src_1 = a; src_2 = b; op = o; in_valid = 1;
      @(negedge clk);
      chk("in_ready_idle", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 0; src_1 = $urandom; src_2 = $urandom; op = 3'($urandom);
      got = 0;
      for (int i = 0; i < N + 3 && !got; i++) begin
         @(negedge clk);
         got = out_valid;
      end
      chk("got_out_valid", got, 1);
      if (got) chk("lit_res", {taken, equal, less, signed_less, illegal}, lit);
      repeat (d) @(negedge clk);
      #1 out_ready = 1;
      @(posedge clk); #1 out_ready = 0;
      @(negedge clk);
      chk("ready_after", in_ready, 1);
      chk("ov_after", out_valid, 0);
   endtask

   initial begin
      #1 rst_n = 0;
      #2;
      chk("rst_outs", {out_valid, taken, equal, less, signed_less, illegal}, 0);
      chk("rst_in_ready", in_ready, 0);
      @(posedge clk); @(posedge clk); #2 rst_n = 1;
      @(negedge clk);
      chk("rel_in_ready", in_ready, 1);

      run(32'h12345678, 32'h12345678, 3'b000, 5'b11000, 5, 0);
      run(32'hFFFFFFFF, 32'h00000001, 3'b100, 5'b10010, 2, 0);
      run(32'hFFFFFFFF, 32'h00000001, 3'b110, 5'b00010, 2, 0);
      run(32'h00000100, 32'h00000200, 3'b111, 5'b00110, 4, 0);
      run(32'h80000000, 32'h7FFFFFFF, 3'b001, 5'b10010, 2, 3);
      run(32'h00000005, 32'h00000009, 3'b010, 5'b00001, 1, 0);
      run(32'h00000005, 32'h00000009, 3'b101, 5'b00110, 5, 0);
      run(32'h80000000, 32'h00000000, 3'b101, 5'b00010, 2, 1);
      run(32'hA5A5A5A5, 32'hA5A5A5A4, 3'b011, 5'b00001, 1, 2);
      run(32'hA5A5A5A5, 32'hA5A5A5A4, 3'b001, 5'b10000, 5, 0);
      run(32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 5'b11000, 5, 0);

      // flush in the second BUSY cycle
      @(posedge clk); #1;
      src_1 = 32'h01020304; src_2 = 32'h01020304; op = 3'b000; in_valid = 1;
      @(posedge clk); #1 in_valid = 0;
      @(posedge clk); #1 flush = 1;
      @(negedge clk);
      chk("flush_in_ready", in_ready, 0);
      @(posedge clk); #1 flush = 0;
      @(negedge clk);
      chk("flush_idle", in_ready, 1);
      chk("flush_ov", out_valid, 0);
      repeat (6) @(negedge clk);

      // asynchronous reset mid-BUSY while DEADBEEF results are still held
      @(posedge clk); #1;
      src_1 = 32'h55555555; src_2 = 32'h55555555; op = 3'b000; in_valid = 1;
      @(posedge clk); #1 in_valid = 0;
      @(posedge clk); #3 rst_n = 0;
      #1;
      chk("async_rst_outs", {out_valid, taken, equal, less, signed_less, illegal}, 0);
      chk("async_rst_in_ready", in_ready, 0);
      @(posedge clk); @(posedge clk); #2 rst_n = 1;
      @(negedge clk);
      chk("rst2_in_ready", in_ready, 1);

      run(32'h00000001, 32'h00000002, 3'b110, 5'b10110, 5, 0);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/branch_comp.md
BRANCH_COMP -- requirements
Module: branch_comp

Interface
REQ-001 SHALL have parameters (name, default, meaning): WIDTH, 32, operand width in bits; CHUNK, 8, bits compared per cycle; WIDTH % CHUNK == 0 and CHUNK >= 1.
REQ-002 SHALL have one clock and an asynchronous, active-low reset (clk, rst_n); ports listed as name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- src_1  in  WIDTH  operand 1.
- src_2  in  WIDTH  operand 2.
- op  in  3  RISC-V branch funct3.
- flush  in  1  synchronous abort of any in-flight request.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- taken  out  1  branch condition true for latched op.
- equal  out  1  src_1 == src_2.
- less  out  1  unsigned src_1 < src_2.
- signed_less  out  1  two's-complement src_1 < src_2.
- illegal  out  1  latched op not a branch code.

Function
REQ-003 SHALL implement FSM IDLE, BUSY, DONE; in_ready = (state == IDLE) && !flush.
REQ-004 On accept SHALL latch src_1, src_2, op; set chunk index idx = WIDTH/CHUNK-1; go to BUSY (legal op) or DONE (illegal op).
REQ-005 Op decode SHALL be: 000 BEQ equal; 001 BNE !equal; 100 BLT signed_less; 101 BGE !signed_less; 110 BLTU less; 111 BGEU !less; 010/011 illegal=1, taken=0, equal/less/signed_less=0.
REQ-006 In BUSY, each cycle SHALL compare chunk idx (bits idx*CHUNK+CHUNK-1 : idx*CHUNK) MSB-first.
- Chunks differ: record less = (chunk_1 < chunk_2), equal = 0; go to DONE.
- Chunks equal, idx == 0: record equal = 1, less = 0; go to DONE.
- Otherwise: idx decrements; stay in BUSY.
REQ-007 signed_less SHALL equal src_1[WIDTH-1] when the top chunk decides and the sign bits differ; otherwise it SHALL equal less.
REQ-008 Latency SHALL be k+1 cycles from the accept edge to the first cycle of out_valid, where k = chunks examined (1..WIDTH/CHUNK). Illegal op latency SHALL be 1 cycle.
REQ-009 In DONE: out_valid = 1; all result outputs SHALL be registered and held stable until out_valid && out_ready; the next state SHALL then be IDLE. No accept is possible in the same cycle.
REQ-010 Outside DONE, out_valid SHALL be 0; result outputs SHALL hold their last values.
REQ-011 flush SHALL force IDLE on the next edge from any state, discarding results (out_valid = 0). flush SHALL take priority over accept and over an out_ready handshake in the same cycle.
REQ-012 CHUNK == WIDTH SHALL yield exactly one BUSY cycle (latency 2).
REQ-013 Changes to src_1, src_2, op after accept SHALL NOT affect the result.

Reset
REQ-014 rst_n low SHALL immediately force IDLE, idx = 0, and out_valid, taken, equal, less, signed_less, illegal = 0, including mid-BUSY or mid-DONE.
REQ-015 in_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release (if flush = 0).

Verification (WIDTH=32, CHUNK=8)
REQ-016 The bench SHALL cover:
- BEQ, src_1 = src_2 = 0x12345678 -> out_valid 5 cycles after accept; equal=1, taken=1, less=0, signed_less=0.
- BLT, src_1=0xFFFFFFFF, src_2=0x00000001 -> latency 2; signed_less=1, less=0, taken=1. Same operands with BLTU -> taken=0.
- BGEU, src_1=0x00000100, src_2=0x00000200 -> latency 4 (chunks 3, 2 equal; chunk 1 decides); less=1, taken=0.
- Backpressure: out_ready=0 for 3 cycles in DONE -> out_valid and results stable, in_ready=0. out_ready=1 -> IDLE next cycle, in_ready=1.
- flush asserted in 2nd BUSY cycle -> IDLE next edge, out_valid never 1. rst_n pulsed low mid-BUSY -> all outputs 0 asynchronously.
- op=010 -> latency 1; illegal=1, taken=0. Next legal request is unaffected.
